// File: rtl/ram_bridge_pkg.sv
// ram_bridge_pkg: shared state codes, counter width and beat-scan helper
package ram_bridge_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CNT_W = 3;
  localparam int MAX_BE = 64;
  function automatic int next_enabled_beat(input logic [MAX_BE-1:0] be, input int k, input int beats, input int bpb);
    int r;
    r = beats;
    for (int j = MAX_BE - 1; j >= 0; j--)
      if (j >= k && j < beats && ((be >> (j * bpb)) & ~({MAX_BE{1'b1}} << bpb)) != '0) r = j;
    return r;
  endfunction
endpackage

// File: rtl/ram_bridge_lat_counter.sv
// ram_lat_counter: loadable down-counter flagging the last read wait cycle
module ram_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt;
  // reload per beat, otherwise count down to zero and stay there
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/ram_bridge.sv
// ram_bridge: splits byte-enabled CPU words into little-endian link beats
module ram_bridge
  import ram_bridge_pkg::*;
#(
  parameter int CPU_W      = 32,
  parameter int LINK_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int EXT_ADDR_W = 16,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [CPU_W/8-1:0]    cpu_be,
  input  logic [CPU_W-1:0]      cpu_wdata,
  output logic [CPU_W-1:0]      cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_busy,
  output logic                  ext_cs,
  output logic                  ext_we,
  output logic                  ext_oe,
  output logic [EXT_ADDR_W-1:0] ext_addr,
  output logic [LINK_W/8-1:0]   ext_be,
  output logic [LINK_W-1:0]     ext_dout,
  input  logic [LINK_W-1:0]     ext_din
);
  localparam int BEATS = CPU_W / LINK_W;
  localparam int BPB = LINK_W / 8;
  localparam int KW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int LB = $clog2(BPB);
  localparam int LK = $clog2(BEATS);

  if (CPU_W % LINK_W != 0 || LINK_W % 8 != 0 || READ_LAT < 0 || READ_LAT > 7) begin : g_bad
    $error("ram_bridge: unsupported CPU_W/LINK_W/READ_LAT combination");
  end

  logic [1:0] state;
  logic we_r;
  logic [EXT_ADDR_W-1:0] base, base_n;
  logic [CPU_W/8-1:0] be_r;
  logic [CPU_W-1:0] wd, rbuf;
  logic [KW-1:0] k;
  logic [ADDR_W-1:0] wa;
  logic lat_done, lat_load;
  int kp1, nb0, nbw;

  // word-aligned link base and the next beat carrying enabled bytes
  always_comb begin
    wa = ((cpu_addr >> LB) >> LK) << LK;
    base_n = EXT_ADDR_W'(wa);
    kp1 = int'(k) + 1;
    nb0 = next_enabled_beat(MAX_BE'(cpu_be), 0, BEATS, BPB);
    nbw = next_enabled_beat(MAX_BE'(be_r), kp1, BEATS, BPB);
  end

  assign lat_load = (state == S_IDLE && cpu_req && !cpu_we) || (state == S_RD && lat_done);

  ram_lat_counter #(.W(CNT_W)) u_lat (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lat_load),
    .en   (state == S_RD),
    .val  (CNT_W'(READ_LAT)),
    .done (lat_done)
  );

  // sequencer: beat outputs are registered so they hold between accesses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      we_r <= 1'b0;
      base <= '0;
      be_r <= '0;
      wd <= '0;
      rbuf <= '0;
      k <= '0;
      ext_addr <= '0;
      ext_be <= '0;
      ext_dout <= '0;
    end else
      case (state)
        S_IDLE:
          if (cpu_req) begin
            we_r <= cpu_we;
            base <= base_n;
            be_r <= cpu_be;
            wd <= cpu_wdata;
            rbuf <= '0;
            if (!cpu_we) begin
              state <= S_RD;
              k <= '0;
              ext_addr <= base_n;
              ext_be <= '1;
            end else if (nb0 < BEATS) begin
              state <= S_WR;
              k <= KW'(nb0);
              ext_addr <= base_n + EXT_ADDR_W'(nb0);
              ext_dout <= cpu_wdata[nb0*LINK_W +: LINK_W];
              ext_be <= cpu_be[nb0*BPB +: BPB];
            end else state <= S_DONE;
          end
        S_RD:
          if (lat_done) begin
            rbuf[k*LINK_W +: LINK_W] <= ext_din;
            if (int'(k) == BEATS - 1) state <= S_DONE;
            else begin
              k <= KW'(kp1);
              ext_addr <= base + EXT_ADDR_W'(kp1);
            end
          end
        S_WR:
          if (nbw < BEATS) begin
            k <= KW'(nbw);
            ext_addr <= base + EXT_ADDR_W'(nbw);
            ext_dout <= wd[nbw*LINK_W +: LINK_W];
            ext_be <= be_r[nbw*BPB +: BPB];
          end else state <= S_DONE;
        default: state <= S_IDLE;
      endcase

  assign cpu_busy = state != S_IDLE;
  assign cpu_ready = state == S_DONE;
  assign cpu_rdata = cpu_ready && !we_r ? rbuf : '0;
  assign ext_cs = state == S_RD || state == S_WR;
  assign ext_we = state == S_WR;
  assign ext_oe = state == S_WR;
endmodule

// File: tb/tb_ram_bridge.sv
// tb_ram_bridge: model-checked directed bench for two ram_bridge configurations
module tb_ram_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic req0, we0, rdy0, busy0, cs0, wex0, oe0;
  logic [31:0] addr0, wd0, rd0;
  logic [3:0] be0;
  logic [15:0] ea0, edo0, edi0;
  logic [1:0] ebe0;

  logic req1, we1, rdy1, busy1, cs1, wex1, oe1;
  logic [31:0] addr1;
  logic [63:0] wd1, rd1;
  logic [7:0] be1, edo1, edi1;
  logic [15:0] ea1;
  logic [0:0] ebe1;

  int n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic cs;
    logic we;
    logic [15:0] addr;
    logic [7:0] be;
    logic [15:0] dout;
    logic cd;
    logic ready;
    logic [63:0] rdata;
  } rec_t;
  rec_t q0[$], q1[$];

  function automatic logic [15:0] din_of(input int id, input logic [15:0] a);
    if (id != 0) return {8'h00, a[3:0], ~a[3:0]};
    if (a == 16'h0082) return 16'h1234;
    if (a == 16'h0083) return 16'hABCD;
    return {a[7:0] ^ 8'h5A, a[7:0]};
  endfunction

  assign edi0 = din_of(0, ea0);
  assign edi1 = 8'(din_of(1, ea1));

  ram_bridge dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_req(req0), .cpu_we(we0), .cpu_addr(addr0), .cpu_be(be0),
    .cpu_wdata(wd0), .cpu_rdata(rd0), .cpu_ready(rdy0), .cpu_busy(busy0), .ext_cs(cs0),
    .ext_we(wex0), .ext_oe(oe0), .ext_addr(ea0), .ext_be(ebe0), .ext_dout(edo0), .ext_din(edi0)
  );

  ram_bridge #(.CPU_W(64), .LINK_W(8), .READ_LAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_req(req1), .cpu_we(we1), .cpu_addr(addr1), .cpu_be(be1),
    .cpu_wdata(wd1), .cpu_rdata(rd1), .cpu_ready(rdy1), .cpu_busy(busy1), .ext_cs(cs1),
    .ext_we(wex1), .ext_oe(oe1), .ext_addr(ea1), .ext_be(ebe1), .ext_dout(edo1), .ext_din(edi1)
  );

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic build(input int id, input logic we, input logic [31:0] a, input logic [7:0] be, input logic [63:0] wd);
    int cw, lw, lat, beats, bpb;
    logic [15:0] base;
    logic [63:0] word;
    logic [7:0] bs;
    rec_t r;
    cw = id != 0 ? 64 : 32;
    lw = id != 0 ? 8 : 16;
    lat = id != 0 ? 0 : 1;
    beats = cw / lw;
    bpb = lw / 8;
    base = 16'((a / 32'(cw / 8)) * 32'(beats));
    word = '0;
    for (int k = 0; k < beats; k++) begin
      if (!we) begin
        for (int w = 0; w <= lat; w++) begin
          r = '0;
          r.cs = 1'b1;
          r.addr = base + 16'(k);
          r.be = 8'((1 << bpb) - 1);
          if (id == 0) q0.push_back(r); else q1.push_back(r);
        end
        word = word | (64'(din_of(id, base + 16'(k))) << (k * lw));
      end else begin
        bs = 8'((be >> (k * bpb)) & 8'((1 << bpb) - 1));
        if (bs != 0) begin
          r = '0;
          r.cs = 1'b1;
          r.we = 1'b1;
          r.addr = base + 16'(k);
          r.be = bs;
          r.dout = 16'((wd >> (k * lw)) & ((64'd1 << lw) - 64'd1));
          r.cd = 1'b1;
          if (id == 0) q0.push_back(r); else q1.push_back(r);
        end
      end
    end
    r = '0;
    r.ready = 1'b1;
    r.rdata = we ? 64'd0 : word;
    if (id == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
  end

  always @(posedge clk)
    if (rst_n) begin
      if (q0.size() != 0) q0.delete(0);
      else if (req0) build(0, we0, addr0, {4'b0, be0}, {32'b0, wd0});
      if (q1.size() != 0) q1.delete(0);
      else if (req1) build(1, we1, addr1, be1, wd1);
    end

  always @(negedge clk)
    if (rst_n) begin
      rec_t r;
      r = q0.size() != 0 ? q0[0] : '0;
      chk("i0_cs", cs0, r.cs);
      chk("i0_we", wex0, r.we);
      chk("i0_oe", oe0, r.we);
      chk("i0_busy", busy0, q0.size() != 0);
      chk("i0_ready", rdy0, r.ready);
      if (r.ready) chk("i0_rdata", rd0, r.rdata);
      if (r.cs) begin
        chk("i0_addr", ea0, r.addr);
        chk("i0_be", ebe0, r.be);
      end
      if (r.cd) chk("i0_dout", edo0, r.dout);
      r = q1.size() != 0 ? q1[0] : '0;
      chk("i1_cs", cs1, r.cs);
      chk("i1_we", wex1, r.we);
      chk("i1_oe", oe1, r.we);
      chk("i1_busy", busy1, q1.size() != 0);
      chk("i1_ready", rdy1, r.ready);
      if (r.ready) chk("i1_rdata", rd1, r.rdata);
      if (r.cs) begin
        chk("i1_addr", ea1, r.addr);
        chk("i1_be", ebe1, r.be);
      end
      if (r.cd) chk("i1_dout", edo1, r.dout);
    end

  task automatic acc(input int id, input logic we, input logic [31:0] a, input logic [7:0] be, input logic [63:0] wd,
                     output int lat, output logic [63:0] rd, output logic [15:0] fa, output logic [7:0] fbe,
                     output logic [15:0] fdo, output int ncs);
    logic got, c, rr;
    @(negedge clk);
    if (id == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; be0 = be[3:0]; wd0 = wd[31:0];
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; be1 = be; wd1 = wd;
    end
    @(posedge clk);
    lat = 0; ncs = 0; rd = '0; fa = '0; fbe = '0; fdo = '0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req0 = 1'b0; req1 = 1'b0;
        addr0 = ~addr0; wd0 = ~wd0; be0 = ~be0;
        addr1 = ~addr1; wd1 = ~wd1; be1 = ~be1;
      end
      c = id != 0 ? cs1 : cs0;
      rr = id != 0 ? rdy1 : rdy0;
      if (c) begin
        if (ncs == 0) begin
          fa = id != 0 ? ea1 : ea0;
          fbe = id != 0 ? 8'(ebe1) : 8'(ebe0);
          fdo = id != 0 ? 16'(edo1) : edo0;
        end
        ncs++;
      end
      if (rr) begin
        got = 1'b1;
        rd = id != 0 ? rd1 : 64'(rd0);
      end
    end
    chk("ready_timeout", got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ncs, n, r1, r2;
    logic [63:0] rd, rdv;
    logic [15:0] fa, fdo;
    logic [7:0] fbe;
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; be0 = 0; wd0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; be1 = 0; wd1 = 0;
    #8;
    chk("rst_cs", cs0, 0); chk("rst_we", wex0, 0); chk("rst_oe", oe0, 0);
    chk("rst_addr", ea0, 0); chk("rst_be", ebe0, 0); chk("rst_dout", edo0, 0);
    chk("rst_ready", rdy0, 0); chk("rst_busy", busy0, 0); chk("rst_rdata", rd0, 0);
    chk("rst1_cs", cs1, 0); chk("rst1_rdata", rd1, 0);
    #14 rst_n = 1'b1;

    acc(0, 1'b0, 32'h0000_0104, 8'h0, 64'h0, lat, rd, fa, fbe, fdo, ncs);
    chk("rd_lat", lat, 5); chk("rd_data", rd, 64'hABCD_1234); chk("rd_addr0", fa, 16'h0082); chk("rd_cs_cycles", ncs, 4);

    acc(0, 1'b1, 32'h0000_0010, 8'hF, 64'hDEAD_BEEF, lat, rd, fa, fbe, fdo, ncs);
    chk("wr_lat", lat, 3); chk("wr_addr0", fa, 16'h0008); chk("wr_be0", fbe, 8'h3);
    chk("wr_dout0", fdo, 16'hBEEF); chk("wr_cs_cycles", ncs, 2); chk("wr_rdata", rd, 0);

    acc(0, 1'b1, 32'h0000_0010, 8'h8, 64'h5A00_0000, lat, rd, fa, fbe, fdo, ncs);
    chk("sp_lat", lat, 2); chk("sp_addr", fa, 16'h0009); chk("sp_be", fbe, 8'h2);
    chk("sp_dout", fdo, 16'h5A00); chk("sp_cs_cycles", ncs, 1);

    acc(0, 1'b1, 32'h0000_0010, 8'h0, 64'h1111_2222, lat, rd, fa, fbe, fdo, ncs);
    chk("be0_lat", lat, 1); chk("be0_cs_cycles", ncs, 0);

    acc(0, 1'b0, 32'h0004_0104, 8'h0, 64'h0, lat, rd, fa, fbe, fdo, ncs);
    chk("trunc_addr", fa, 16'h0082); chk("trunc_data", rd, 64'hABCD_1234);

    acc(1, 1'b0, 32'h0000_0008, 8'h0, 64'h0, lat, rd, fa, fbe, fdo, ncs);
    chk("sw_lat", lat, 9); chk("sw_data", rd, 64'hF0E1_D2C3_B4A5_9687);
    chk("sw_addr0", fa, 16'h0008); chk("sw_cs_cycles", ncs, 8);

    acc(1, 1'b1, 32'h0000_0008, 8'b0010_0100, 64'h0011_2233_4455_6677, lat, rd, fa, fbe, fdo, ncs);
    chk("sw_wr_lat", lat, 3); chk("sw_wr_addr0", fa, 16'h000A);
    chk("sw_wr_be0", fbe, 8'h1); chk("sw_wr_dout0", fdo, 16'h0055); chk("sw_wr_cs", ncs, 2);

    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; be0 = 4'hF; wd0 = 32'hDEAD_BEEF;
    @(posedge clk);
    n = 0; r1 = 0; r2 = 0; rdv = '0;
    repeat (30) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        we0 = 1'b0;
        addr0 = 32'h104;
      end
      if (n == 4) chk("b2b_gap_cs", cs0, 0);
      if (n == 5) req0 = 1'b0;
      if (rdy0) begin
        if (r1 == 0) r1 = n;
        else if (r2 == 0) begin
          r2 = n;
          rdv = 64'(rd0);
        end
      end
    end
    chk("b2b_first_ready", r1, 3); chk("b2b_second_ready", r2, 9); chk("b2b_rdata", rdv, 64'hABCD_1234);

    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h104;
    @(posedge clk);
    @(negedge clk) req0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_cs", cs0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", cs0, 0); chk("arst_oe", oe0, 0); chk("arst_busy", busy0, 0);
    chk("arst_ready", rdy0, 0); chk("arst_addr", ea0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_ready", rdy0, 0);
    end
    #2 rst_n = 1'b1;
    acc(0, 1'b0, 32'h0000_0104, 8'h0, 64'h0, lat, rd, fa, fbe, fdo, ncs);
    chk("post_rst_lat", lat, 5); chk("post_rst_data", rd, 64'hABCD_1234);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
